// File: rtl/cave_pkg.sv
// Shared definitions for the CAVE core's HPS ioctl plumbing: index map,
// upload responder state type and the 68k-to-HPS byte swap.
package cave_pkg;

  localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    DRAIN
  } upload_state_e;

  // 68k memory is big-endian; the HPS expects the low byte first.
  function automatic logic [15:0] swap16(input logic [15:0] word);
    return {word[7:0], word[15:8]};
  endfunction

endpackage

// File: rtl/nvram_uploader.sv
// Serves NVRAM contents to the HPS over the ioctl upload path, turning each
// ioctl_rd byte address into one word read on the memory arbiter port.
module nvram_uploader
  import cave_pkg::*;
#(
  parameter logic [7:0]  INDEX      = IOCTL_IDX_NVRAM,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned SIZE_BYTES = 128,
  parameter bit          SWAP_BYTES = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_wait_req,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
);

  localparam logic [31:0] SIZE_LIMIT = 32'(SIZE_BYTES);

  upload_state_e state, state_d;
  logic          aborted, aborted_d;
  logic [15:0]   ioctl_din_d;
  logic          ioctl_wait_d;
  logic          mem_rd_d;
  logic [31:0]   mem_addr_d;
  logic [15:0]   word_count_d;
  logic [15:0]   count_base;
  logic [15:0]   mem_word;
  logic          count_word;
  logic          sel;
  logic          session_start;
  logic          in_range;

  assign sel           = ioctl_upload & (ioctl_index == INDEX);
  assign session_start = sel & ~busy;
  assign in_range      = {7'd0, ioctl_addr} < SIZE_LIMIT;
  assign mem_word      = SWAP_BYTES ? swap16(mem_data) : mem_data;
  assign count_base    = session_start ? 16'd0 : word_count;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state;
    aborted_d   = aborted;
    ioctl_din_d = ioctl_din;
    mem_rd_d    = mem_rd;
    mem_addr_d  = mem_addr;
    count_word  = 1'b0;

    unique case (state)
      IDLE: begin
        // A strobe while ioctl_wait is still high is a protocol violation.
        if (ioctl_rd && sel && !ioctl_wait) begin
          if (in_range) begin
            state_d    = REQ;
            aborted_d  = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = BASE_ADDR + {7'd0, ioctl_addr};
          end else begin
            ioctl_din_d = 16'hFFFF;
            count_word  = 1'b1;
          end
        end
      end
      REQ: begin
        // Requests are never withdrawn; an abort only decides where the data goes.
        aborted_d = aborted | ~sel;
        if (!mem_wait_req) begin
          mem_rd_d = 1'b0;
          if (mem_valid) begin
            state_d = IDLE;
            if (!aborted_d) begin
              ioctl_din_d = mem_word;
              count_word  = 1'b1;
            end
          end else begin
            state_d = aborted_d ? DRAIN : WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (mem_valid) begin
          state_d = IDLE;
          if (sel) begin
            ioctl_din_d = mem_word;
            count_word  = 1'b1;
          end
        end else if (!sel) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stall covers the cycle after leaving a busy state so ioctl_din settles first.
    ioctl_wait_d = sel & ~((state == IDLE) && (state_d == IDLE));

    if (count_word)
      word_count_d = (count_base == 16'hFFFF) ? count_base : count_base + 16'd1;
    else
      word_count_d = count_base;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset_n) begin
      state      <= IDLE;
      aborted    <= 1'b0;
      ioctl_din  <= 16'd0;
      ioctl_wait <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= 16'd0;
    end else begin
      state      <= state_d;
      aborted    <= aborted_d;
      ioctl_din  <= ioctl_din_d;
      ioctl_wait <= ioctl_wait_d;
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      busy       <= sel;
      done       <= busy & ~sel;
      word_count <= word_count_d;
    end
  end

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader: HPS reads, memory stalls, out-of-range,
// full upload, session abort, wrong index and reset during a request.
module tb_nvram_uploader;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_wait_req;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        busy;
  logic        done;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder configuration (main sequence) and statistics (responder).
  int          stall_cfg   = 0;
  int          valid_delay = 1;
  int          accept_count = 0;
  int          addr_moved  = 0;
  int          done_count  = 0;
  logic [31:0] last_addr   = 32'd0;
  logic [15:0] mem_model [64];

  nvram_uploader #(
    .INDEX      (8'd4),
    .BASE_ADDR  (BASE),
    .SIZE_BYTES (128),
    .SWAP_BYTES (1'b1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_wait_req (mem_wait_req),
    .mem_data     (mem_data),
    .mem_valid    (mem_valid),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory port model: stalls stall_cfg cycles, returns data valid_delay cycles after accept.
  initial begin
    automatic bit          in_req   = 1'b0;
    automatic int          stall_left = 0;
    automatic int          pend_cnt = 0;
    automatic logic [15:0] pend_data = 16'd0;
    automatic logic [31:0] req_addr = 32'd0;
    automatic logic [31:0] offset;
    mem_wait_req = 1'b0;
    mem_valid    = 1'b0;
    mem_data     = 16'd0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = pend_data;
        end
      end
      if (mem_rd) begin
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = stall_cfg;
          req_addr   = mem_addr;
        end else if (mem_addr != req_addr) begin
          addr_moved++;
        end
        if (stall_left > 0) begin
          mem_wait_req = 1'b1;
          stall_left--;
        end else begin
          mem_wait_req = 1'b0;
          in_req       = 1'b0;
          accept_count++;
          last_addr = mem_addr;
          offset    = mem_addr - BASE;
          if (valid_delay == 0) begin
            mem_valid = 1'b1;
            mem_data  = mem_model[offset[6:1]];
          end else begin
            pend_cnt  = valid_delay;
            pend_data = mem_model[offset[6:1]];
          end
        end
      end else begin
        mem_wait_req = 1'b0;
        in_req       = 1'b0;
      end
    end
  end

  always @(negedge clk_sys) if (done === 1'b1) done_count++;

  // Issue one HPS read at a negedge; returns how many cycles ioctl_wait stayed high.
  task automatic hps_read(input logic [24:0] addr, input bit hold_rd, output int n);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    if (!hold_rd) ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    ioctl_rd = 1'b0;
  endtask

  initial begin
    int          n;
    int          acc0;
    int          done0;
    int          bad;
    logic [15:0] exp;

    for (int i = 0; i < 64; i++) mem_model[i] = 16'h5A00 | 16'(i);
    mem_model[1] = 16'h1234;

    reset_n      = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 25'd0;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("rst_din",   32'(ioctl_din),  32'h0);
    check("rst_wait",  32'(ioctl_wait), 32'h0);
    check("rst_mem_rd", 32'(mem_rd),    32'h0);
    check("rst_mem_addr", mem_addr,     32'h0);
    check("rst_busy",  32'(busy),       32'h0);
    check("rst_done",  32'(done),       32'h0);
    check("rst_wc",    32'(word_count), 32'h0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Session A
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    @(negedge clk_sys);
    check("a_busy", 32'(busy), 32'h1);

    hps_read(25'd2, 1'b0, n);
    check("basic_wait_cycles", 32'(n), 32'd3);
    check("basic_mem_addr", last_addr, 32'h0010_0002);
    check("basic_din", 32'(ioctl_din), 32'h3412);
    check("basic_wc", 32'(word_count), 32'd1);

    stall_cfg = 5;
    hps_read(25'd4, 1'b0, n);
    stall_cfg = 0;
    check("stall_wait_cycles", 32'(n), 32'd8);
    check("stall_addr_stable", 32'(addr_moved), 32'd0);
    check("stall_mem_addr", last_addr, 32'h0010_0004);
    check("stall_din", 32'(ioctl_din), 32'h025A);
    check("stall_wc", 32'(word_count), 32'd2);

    valid_delay = 0;
    hps_read(25'd6, 1'b0, n);
    valid_delay = 1;
    check("acc_valid_wait_cycles", 32'(n), 32'd2);
    check("acc_valid_din", 32'(ioctl_din), 32'h035A);
    check("acc_valid_wc", 32'(word_count), 32'd3);

    acc0 = accept_count;
    hps_read(25'd128, 1'b0, n);
    check("oor_wait_cycles", 32'(n), 32'd0);
    check("oor_no_mem_rd", 32'(accept_count - acc0), 32'd0);
    check("oor_din", 32'(ioctl_din), 32'hFFFF);
    check("oor_wc", 32'(word_count), 32'd4);

    acc0 = accept_count;
    hps_read(25'd8, 1'b1, n);
    repeat (2) @(negedge clk_sys);
    check("viol_wait_cycles", 32'(n), 32'd3);
    check("viol_single_req", 32'(accept_count - acc0), 32'd1);
    check("viol_din", 32'(ioctl_din), 32'h045A);
    check("viol_wc", 32'(word_count), 32'd5);

    done0 = done_count;
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("a_end_done", 32'(done_count - done0), 32'd1);
    check("a_end_wc_hold", 32'(word_count), 32'd5);

    // Session B: full upload
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("b_wc_cleared", 32'(word_count), 32'd0);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      hps_read(25'(2 * i), 1'b0, n);
      exp = {mem_model[i][7:0], mem_model[i][15:8]};
      if (ioctl_din !== exp || n != 3) bad++;
    end
    check("full_words", 32'(bad), 32'd0);
    check("full_wc", 32'(word_count), 32'd64);
    done0 = done_count;
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("full_done_once", 32'(done_count - done0), 32'd1);
    check("full_busy_low", 32'(busy), 32'h0);
    check("full_wc_hold", 32'(word_count), 32'd64);

    // Wrong index
    acc0  = accept_count;
    done0 = done_count;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd0;
    @(negedge clk_sys);
    hps_read(25'd2, 1'b0, n);
    repeat (3) @(negedge clk_sys);
    check("widx_wait_cycles", 32'(n), 32'd0);
    check("widx_no_mem_rd", 32'(accept_count - acc0), 32'd0);
    check("widx_din", 32'(ioctl_din), 32'h3F5A);
    check("widx_busy", 32'(busy), 32'h0);
    check("widx_wc", 32'(word_count), 32'd64);
    check("widx_no_done", 32'(done_count - done0), 32'd0);
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd4;
    @(negedge clk_sys);

    // Session C: abort in WAIT_DATA with a late response
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("c_wc_cleared", 32'(word_count), 32'd0);
    acc0  = accept_count;
    done0 = done_count;
    valid_delay = 4;
    ioctl_addr  = 25'd10;
    ioctl_rd    = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("abort_wait_req", 32'(ioctl_wait), 32'h1);
    @(negedge clk_sys);
    check("abort_wait_data", 32'(ioctl_wait), 32'h1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_wait_drop", 32'(ioctl_wait), 32'h0);
    repeat (6) @(negedge clk_sys);
    valid_delay = 1;
    check("abort_din_kept", 32'(ioctl_din), 32'h3F5A);
    check("abort_wc", 32'(word_count), 32'd0);
    check("abort_one_req", 32'(accept_count - acc0), 32'd1);
    check("abort_done", 32'(done_count - done0), 32'd1);

    // Session D: back in IDLE after the drain
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    hps_read(25'd12, 1'b0, n);
    check("post_abort_wait_cycles", 32'(n), 32'd3);
    check("post_abort_din", 32'(ioctl_din), 32'h065A);
    check("post_abort_wc", 32'(word_count), 32'd1);

    // Reset while a stalled request is pending
    stall_cfg  = 10;
    ioctl_addr = 25'd14;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("midrst_pre_mem_rd", 32'(mem_rd), 32'h1);
    check("midrst_pre_wait", 32'(ioctl_wait), 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_din", 32'(ioctl_din), 32'h0);
    check("midrst_wait", 32'(ioctl_wait), 32'h0);
    check("midrst_mem_rd", 32'(mem_rd), 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_wc", 32'(word_count), 32'h0);
    stall_cfg    = 0;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- HPS-side upload responder: serves battery/EEPROM backup contents from the core's backing memory to the HPS over the ioctl upload path, i.e. ioctl_rd/ioctl_din/ioctl_wait.
- It is the read direction of the ROM download path, which uses ioctl_wr/ioctl_dout/ioctl_wait.
- It sits between hps_io and the memory arbiter port that owns the NVRAM region.
- It converts HPS byte addresses into word reads, stalls the HPS with ioctl_wait for variable memory latency, and reports completion.

Parameters:
- INDEX, 8'd4: ioctl_index value this block answers; other indices are ignored.
- BASE_ADDR, 32'h0: byte base of the NVRAM region in the memory port address space.
- SIZE_BYTES, 128: region length in bytes; must be even.
- SWAP_BYTES, 1: when 1, ioctl_din = {mem_data[7:0], mem_data[15:8]} (68k big-endian to HPS little-endian).

Ports:
- clock  in  1  system clock (clk_sys domain)
- reset_n  in  1  asynchronous, active-low reset
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  8  upload target index
- ioctl_rd  in  1  one-cycle read strobe from HPS
- ioctl_addr  in  25  byte address, always even
- ioctl_din  out  16  word returned to HPS
- ioctl_wait  out  1  stall; HPS issues no new ioctl_rd while high
- mem_rd  out  1  memory read request
- mem_addr  out  32  byte address = BASE_ADDR + ioctl_addr
- mem_wait_req  in  1  memory not accepting; mem_rd/mem_addr are held while high
- mem_data  in  16  read data
- mem_valid  in  1  mem_data valid (single-word response)
- busy  out  1  upload session active for INDEX
- done  out  1  one-cycle pulse at session end
- word_count  out  16  words served in the current or last session

Behaviour:
- Reset values (async, reset_n low): ioctl_din=0, ioctl_wait=0, mem_rd=0, mem_addr=0, busy=0, done=0, word_count=0, state=IDLE.
- sel = ioctl_upload & (ioctl_index==INDEX). busy = registered sel.
  - Rising edge of busy: clears word_count.
  - Falling edge of busy: done=1 for exactly one cycle.
- FSM states: IDLE, REQ, WAIT_DATA, DRAIN.
  - IDLE, ioctl_rd & sel, addr < SIZE_BYTES: next cycle ioctl_wait=1, mem_rd=1, mem_addr latched; go to REQ.
  - IDLE, ioctl_rd & sel, addr >= SIZE_BYTES: no memory access. Next cycle ioctl_din=16'hFFFF, ioctl_wait stays 0, word_count+1.
  - REQ: hold mem_rd/mem_addr while mem_wait_req=1. First cycle with mem_wait_req=0 is the accept: mem_rd drops next cycle; go to WAIT_DATA.
  - WAIT_DATA, mem_valid: register ioctl_din (swapped per SWAP_BYTES). Next cycle ioctl_wait=0, word_count+1; go to IDLE.
  - mem_valid in the accept cycle itself is legal and is handled identically.
- Latency: with zero memory wait and mem_valid 1 cycle after accept, ioctl_wait is high for exactly 3 cycles. ioctl_din is valid from the cycle ioctl_wait falls and holds until the next completed read.
- ioctl_rd while ioctl_wait=1 is a protocol violation: ignored, no second request.
- ioctl_rd with sel=0 is ignored entirely; ioctl_din and ioctl_wait are unchanged.
- Session abort: sel falls while in REQ or WAIT_DATA.
  - ioctl_wait drops next cycle.
  - An already-accepted request must still consume its mem_valid: go to DRAIN, discard the data, then IDLE; word_count is not incremented.
  - An unaccepted request in REQ keeps mem_rd asserted until accepted, then DRAINs. Requests are never withdrawn from the arbiter.
- New session starting while in DRAIN: ioctl_rd is not serviced until IDLE; ioctl_wait=1 while DRAIN & sel.
- word_count saturates at 16'hFFFF.
- Address arithmetic is 32-bit unsigned; wrap past 2^32 is not checked.

Decomposition:
- Shared package (cave_pkg): ioctl index constants (ROM download, NVRAM) and the upload state enum type.
- Single flat module. The byte-swap is one assign and needs no sub-module.
- Optional reuse: a small edge_detect sub-module for the busy rise/fall, if the package already provides one.

Test Plan:
- Basic read: SIZE_BYTES=128, BASE_ADDR=32'h0010_0000, memory word at 32'h0010_0002 = 16'h1234. ioctl_rd at addr 2 -> mem_addr=32'h0010_0002, ioctl_wait high 3 cycles, ioctl_din=16'h3412 (SWAP_BYTES=1), word_count=1.
- Memory stall: mem_wait_req high 5 cycles after the request -> mem_rd/mem_addr stable throughout, ioctl_wait high 8 cycles, correct data returned.
- Out of range: ioctl_rd at addr 128 -> no mem_rd, ioctl_din=16'hFFFF, ioctl_wait never rises.
- Full upload: 64 sequential reads at addr 0..126, then ioctl_upload falls -> word_count=64, done pulses exactly once, busy=0.
- Abort: ioctl_upload falls in the WAIT_DATA state -> ioctl_wait falls next cycle, the late mem_valid is absorbed without an ioctl_din change, state returns to IDLE, word_count unchanged.
- Wrong index or reset mid-op: ioctl_index=0 with ioctl_rd -> no activity. reset_n low during REQ -> all outputs at reset values immediately.
